// File: rtl/key_conditioner_if.sv
`timescale 1ns/1ps
// Key conditioner bundle: raw active-low key levels in, single-cycle command pulses out.
interface key_conditioner_if;
    logic btn_up_n;
    logic btn_down_n;
    logic btn_sel_n;
    logic up_pulse;
    logic down_pulse;
    logic sel_pulse;

    // The keypad side drives the raw keys and listens to the commands.
    modport master (
        output btn_up_n,
        output btn_down_n,
        output btn_sel_n,
        input  up_pulse,
        input  down_pulse,
        input  sel_pulse
    );

    // The conditioner consumes raw keys and produces the commands.
    modport slave (
        input  btn_up_n,
        input  btn_down_n,
        input  btn_sel_n,
        output up_pulse,
        output down_pulse,
        output sel_pulse
    );
endinterface

// File: rtl/key_conditioner.sv
`timescale 1ns/1ps
// Key conditioner: synchronizes, debounces and auto-repeats three push keys
// (UP, DOWN, SELECT) and turns them into registered single-cycle commands.
// UP and DOWN are mutually exclusive; SELECT fires once per press.
module key_conditioner #(
    parameter int DB_CYCLES   = 500_000,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int RPT_CYCLES  = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    key_conditioner_if.slave keys
);

    localparam int NUM_CH  = 3;
    localparam int CH_UP   = 0;
    localparam int CH_DOWN = 1;
    localparam int CH_SEL  = 2;

    localparam int MAX_DH     = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > RPT_CYCLES) ? MAX_DH : RPT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HOLD,
        REPEAT,
        DB_REL
    } state_e;

    logic [NUM_CH-1:0] raw_n;
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] fire_vec;
    logic [NUM_CH-1:0] idle_vec;

    logic up_pulse_q;
    logic down_pulse_q;
    logic sel_pulse_q;

    assign raw_n = {keys.btn_sel_n, keys.btn_down_n, keys.btn_up_n};

    // Two-flop synchronizer for the asynchronous keys; resets to "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        localparam bit AUTO_RPT = (g != CH_SEL);

        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pressed;
        logic             fire;

        assign pressed = ~sync2_q[g];

        // Channel state and shared debounce/hold/repeat counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: the counter is always cleared before it could pass its terminal value.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = DB_PRESS;
                        cnt_d   = '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!pressed) begin
                        state_d = DB_REL;
                        cnt_d   = '0;
                    end else if (AUTO_RPT) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!pressed) begin
                        state_d = DB_REL;
                        cnt_d   = '0;
                    end else if (cnt_q == RPT_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DB_REL: begin
                    if (pressed) begin
                        cnt_d = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Fire request on the edges that complete debounce, hold delay or a repeat period.
        always_comb begin
            fire = 1'b0;
            case (state_q)
                DB_PRESS: fire = pressed && (cnt_q == DB_LAST);
                HOLD:     fire = AUTO_RPT && pressed && (cnt_q == HOLD_LAST);
                REPEAT:   fire = pressed && (cnt_q == RPT_LAST);
                default:  fire = 1'b0;
            endcase
        end

        assign fire_vec[g] = fire;
        assign idle_vec[g] = (state_q == IDLE);
    end

    // Registered command pulses; UP and DOWN drop requests while the other key is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            sel_pulse_q  <= 1'b0;
        end else begin
            up_pulse_q   <= fire_vec[CH_UP] & idle_vec[CH_DOWN];
            down_pulse_q <= fire_vec[CH_DOWN] & idle_vec[CH_UP];
            sel_pulse_q  <= fire_vec[CH_SEL];
        end
    end

    assign keys.up_pulse   = up_pulse_q;
    assign keys.down_pulse = down_pulse_q;
    assign keys.sel_pulse  = sel_pulse_q;

endmodule
